// File: rtl/cpstr_mgr_rx.sv
// Demultiplexes an escape-coded byte stream onto NUM_STREAMS output streams.
// One holding register carries each byte to the selected lane, one byte per cycle.
module cpstr_mgr_rx #(
   parameter int unsigned  NUM_STREAMS = 3,
   parameter logic [7:0]   ESC_CHAR    = 8'd27,
   localparam int unsigned IDX_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [7:0]               i_data,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic [8*NUM_STREAMS-1:0] o_data,
   output logic [NUM_STREAMS-1:0]   o_valid,
   input  logic [NUM_STREAMS-1:0]   i_ready,
   output logic [IDX_W-1:0]         o_stridx,
   output logic                     o_stridx_valid,
   output logic                     o_err
);

   localparam logic [7:0] NUM_B = 8'(NUM_STREAMS);

   typedef enum logic {S_DATA, S_ESC} state_e;

   state_e           state_q;
   logic             full_q;
   logic [7:0]       byte_q;
   logic [IDX_W-1:0] held_idx_q;
   logic [IDX_W-1:0] sel_idx_q;
   logic             sel_valid_q;
   logic             err_q;

   logic take;
   logic accept;
   logic is_esc;
   logic is_sel;
   logic is_data;

   always_comb begin
      take    = full_q && i_ready[held_idx_q];
      // Control bytes also wait on a blocked holding register, keeping ordering simple.
      o_ready = !full_q || i_ready[held_idx_q];
      accept  = i_valid && o_ready;
      is_esc  = (i_data == ESC_CHAR);
      is_sel  = (state_q == S_ESC) && !is_esc && (i_data < NUM_B);
      is_data = (state_q == S_DATA) ? !is_esc : is_esc;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_DATA;
         full_q      <= 1'b0;
         byte_q      <= 8'h00;
         held_idx_q  <= '0;
         sel_idx_q   <= '0;
         sel_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (take) begin
            full_q <= 1'b0;
         end
         if (accept) begin
            state_q <= (state_q == S_DATA && is_esc) ? S_ESC : S_DATA;
            if (is_data) begin
               // A load in the same cycle as a take overrides the clear: no bubble.
               if (sel_valid_q) begin
                  full_q     <= 1'b1;
                  byte_q     <= i_data;
                  held_idx_q <= sel_idx_q;
               end else begin
                  err_q <= 1'b1;
               end
            end else if (is_sel) begin
               sel_idx_q   <= i_data[IDX_W-1:0];
               sel_valid_q <= 1'b1;
            end else if (state_q == S_ESC) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_valid = '0;
      if (full_q) begin
         o_valid[held_idx_q] = 1'b1;
      end
   end

   assign o_data         = {NUM_STREAMS{byte_q}};
   assign o_stridx       = sel_idx_q;
   assign o_stridx_valid = sel_valid_q;
   assign o_err          = err_q;

endmodule

// File: tb/tb_cpstr_mgr_rx.sv
// Directed bench for cpstr_mgr_rx: protocol-level reference model checked every cycle,
// plus literal expectations on delivered bytes, error counts and throughput.
module tb_cpstr_mgr_rx;

   localparam int NS = 3;
   localparam logic [7:0] ESC = 8'd27;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [7:0]    i_data = 8'h00;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [8*NS-1:0] o_data;
   logic [NS-1:0] o_valid;
   logic [NS-1:0] i_ready = '1;
   logic [1:0]    o_stridx;
   logic          o_stridx_valid;
   logic          o_err;

   cpstr_mgr_rx #(
      .NUM_STREAMS(NS),
      .ESC_CHAR   (ESC)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_stridx      (o_stridx),
      .o_stridx_valid(o_stridx_valid),
      .o_err         (o_err)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;
   int err_cnt = 0;
   int cyc = 0;
   logic [9:0] got[$];
   logic [9:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_got(input string name);
      chk({name, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         chk(name, {22'd0, got[i]}, {22'd0, exp_q[i]});
      end
   endtask

   // Reference model: protocol state as plain variables, updated with what the link saw.
   bit m_esc = 0, m_full = 0, m_selv = 0, m_err = 0;
   int m_idx = 0, m_sel = 0;
   logic [7:0] m_byte = 8'h00;

   always begin
      bit m_rdy, data_b;
      @(posedge i_clk);
      #1;
      if (i_rst) begin
         m_esc = 0; m_full = 0; m_selv = 0; m_err = 0;
         m_idx = 0; m_sel = 0; m_byte = 8'h00;
      end else begin
         m_rdy  = !m_full || i_ready[m_idx];
         m_err  = 0;
         data_b = 0;
         if (i_valid && m_rdy) begin
            if (!m_esc) begin
               if (i_data == ESC) m_esc = 1;
               else data_b = 1;
            end else begin
               m_esc = 0;
               if (i_data == ESC) data_b = 1;
               else if (int'(i_data) < NS) begin
                  m_sel = int'(i_data);
                  m_selv = 1;
               end else m_err = 1;
            end
            if (data_b && !m_selv) m_err = 1;
         end
         if (m_full && i_ready[m_idx]) m_full = 0;
         if (data_b && m_selv) begin
            m_full = 1;
            m_byte = i_data;
            m_idx  = m_sel;
         end
      end
      chk("o_valid", {29'd0, o_valid}, m_full ? (32'd1 << m_idx) : 32'd0);
      chk("o_data", {8'd0, o_data}, {8'd0, {NS{m_byte}}});
      chk("o_err", {31'd0, o_err}, {31'd0, m_err});
      chk("o_stridx_valid", {31'd0, o_stridx_valid}, {31'd0, m_selv});
      chk("o_stridx", {30'd0, o_stridx}, m_sel);
      chk("o_ready", {31'd0, o_ready}, {31'd0, (!m_full || i_ready[m_idx])});
   end

   // Delivery log and error-pulse counter, sampled mid-cycle.
   always @(negedge i_clk) begin
      cyc++;
      if (!i_rst) begin
         err_cnt += int'(o_err);
         for (int k = 0; k < NS; k++) begin
            if (o_valid[k] && i_ready[k]) got.push_back({2'(k), o_data[8*k +: 8]});
         end
      end
   end

   task automatic send(input logic [7:0] b);
      i_valid = 1'b1;
      i_data  = b;
      for (int n = 0; ; n++) begin
         @(negedge i_clk);
         if (o_ready) break;
         if (n > 200) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge i_clk);
      #3;
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #3;
   endtask

   int e0, c0;

   initial begin
      idle(3);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_valid", {29'd0, o_valid}, 32'd0);
      chk("rst_data", {8'd0, o_data}, 32'd0);
      i_rst = 1'b0;
      idle(1);

      // Data before any selection is dropped with an error.
      send(8'h05);
      idle(2);
      chk("nosel_err", err_cnt, 1);
      chk("nosel_out", got.size(), 0);
      send(ESC); send(8'h01); send(8'h10); send(8'h11);
      idle(3);
      exp_q = {}; exp_q.push_back({2'd1, 8'h10}); exp_q.push_back({2'd1, 8'h11});
      check_got("sel1");
      chk("sel1_idx", {30'd0, o_stridx}, 32'd1);

      // Literal escape, then an out-of-range index.
      got = {}; e0 = err_cnt;
      send(ESC); send(ESC);
      idle(3);
      exp_q = {}; exp_q.push_back({2'd1, 8'h1B});
      check_got("literal");
      send(ESC); send(8'h07);
      idle(3);
      chk("badidx_err", err_cnt - e0, 1);
      chk("badidx_idx", {30'd0, o_stridx}, 32'd1);
      chk("badidx_out", got.size(), 1);

      // Full-rate streaming to stream 0.
      got = {};
      c0 = cyc;
      send(ESC); send(8'h00);
      for (int i = 0; i < 16; i++) send(8'(i));
      chk("rate_cycles", cyc - c0, 18);
      idle(3);
      exp_q = {};
      for (int i = 0; i < 16; i++) exp_q.push_back({2'd0, 8'(i)});
      check_got("stream0");

      // Backpressure on stream 2.
      got = {}; e0 = err_cnt;
      send(ESC); send(8'h02);
      send(ESC); send(8'h02);
      i_ready = 3'b011;
      send(8'h30);
      fork
         send(8'h31);
         begin
            repeat (10) @(posedge i_clk);
            #1;
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            chk("bp_hold", {24'd0, o_data[23:16]}, 32'h30);
            #2;
            i_ready = 3'b111;
         end
      join
      send(8'h32);
      idle(3);
      chk("resel_silent", err_cnt - e0, 0);
      exp_q = {};
      exp_q.push_back({2'd2, 8'h30}); exp_q.push_back({2'd2, 8'h31});
      exp_q.push_back({2'd2, 8'h32});
      check_got("bp");

      // Held byte keeps its lane across a stream switch.
      got = {};
      i_ready = 3'b110;
      fork
         begin
            send(ESC); send(8'h00); send(8'hA0); send(ESC); send(8'h02); send(8'hA1);
         end
         begin
            repeat (6) @(posedge i_clk);
            #1;
            chk("sw_valid", {29'd0, o_valid}, 32'd1);
            chk("sw_byte", {24'd0, o_data[7:0]}, 32'hA0);
            chk("sw_ready", {31'd0, o_ready}, 32'd0);
            #2;
            i_ready = 3'b111;
         end
      join
      idle(3);
      exp_q = {}; exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd2, 8'hA1});
      check_got("switch");

      // Reset mid-escape discards the escape and the selection.
      got = {};
      send(ESC);
      i_rst = 1'b1;
      idle(2);
      i_rst = 1'b0;
      idle(1);
      e0 = err_cnt;
      send(8'h00);
      idle(3);
      chk("rst_esc_err", err_cnt - e0, 1);
      chk("rst_esc_out", got.size(), 0);
      chk("rst_esc_selv", {31'd0, o_stridx_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
